// File: rtl/bird_ctrl.sv
// bird_ctrl: vertical-motion controller for the bird in a flappy-style game.
//
// Three-state machine (IDLE, FLY, DEAD). In FLY the bird drops one row every
// FALL_TICKS cycles, rises FLAP_ROWS rows on each flap, and dies on a pipe hit
// or on falling off row 0. All outputs except bird_onehot are registered.
//
// Ports:
//   clk          in   system clock, all state on posedge
//   reset        in   synchronous, active-high
//   flap         in   single-cycle press pulse
//   hit          in   pipe collision flag
//   bird_row     out  [2:0] bird row, 0 = bottom, 7 = top
//   bird_onehot  out  [7:0] one-hot decode of bird_row
//   playing      out  high while in FLY
//   dead         out  high while in DEAD
//
// Build option: define BIRD_CEIL_KILL_EN to make a flap in FLY that would pass
// row 7 kill the bird (row set to 7). Undefined, the row clamps at 7 and the
// bird keeps flying.

module bird_ctrl #(
    parameter int unsigned FALL_TICKS = 8,
    parameter int unsigned FLAP_ROWS  = 2,
    parameter int unsigned START_ROW  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flap,
    input  logic       hit,
    output logic [2:0] bird_row,
    output logic [7:0] bird_onehot,
    output logic       playing,
    output logic       dead
);

    typedef enum logic [1:0] {
        StIdle,
        StFly,
        StDead
    } state_e;

    localparam logic [23:0] FallLast  = 24'(FALL_TICKS - 1);
    localparam logic [3:0]  FlapRows  = 4'(FLAP_ROWS);
    localparam logic [2:0]  StartRow  = 3'(START_ROW);

    state_e      state_q, state_d;
    logic [2:0]  row_q, row_d;
    logic [23:0] cnt_q, cnt_d;
    logic        playing_q, dead_q;

    // Row sum kept at 4 bits so a flap near the top never wraps to a low row.
    logic [3:0]  row_up;
    logic        row_over;
    logic [2:0]  row_clamped;
    logic        fall_step;

    always_comb begin
        row_up      = {1'b0, row_q} + FlapRows;
        row_over    = (row_up > 4'd7);
        row_clamped = row_over ? 3'd7 : row_up[2:0];
        fall_step   = (cnt_q == FallLast);
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = 24'd0;
                if (flap) begin
                    state_d = StFly;
                    row_d   = row_clamped;
                end
            end
            StFly: begin
                // Priority: hit, then flap, then fall step.
                if (hit) begin
                    state_d = StDead;
                end else if (flap) begin
                    cnt_d = 24'd0;
                    row_d = row_clamped;
`ifdef BIRD_CEIL_KILL_EN
                    if (row_over) begin
                        state_d = StDead;
                    end
`endif
                end else if (fall_step) begin
                    cnt_d = 24'd0;
                    if (row_q != 3'd0) begin
                        row_d = row_q - 3'd1;
                    end else begin
                        state_d = StDead;
                    end
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            StDead: begin
                // Frozen until reset.
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            row_q     <= StartRow;
            cnt_q     <= 24'd0;
            playing_q <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            playing_q <= (state_d == StFly);
            dead_q    <= (state_d == StDead);
        end
    end

    assign bird_row = row_q;
    assign playing  = playing_q;
    assign dead     = dead_q;

    always_comb begin
        bird_onehot = 8'd0;
        bird_onehot[row_q] = 1'b1;
    end

endmodule

// File: tb/tb_bird_ctrl.sv
// Scoreboard bench for bird_ctrl with default parameters.
// Stimulus pushes cycle-stamped expected outputs; a monitor on the falling
// edge pops and compares them.

module tb_bird_ctrl;

    logic       clk;
    logic       reset;
    logic       flap;
    logic       hit;
    logic [2:0] bird_row;
    logic [7:0] bird_onehot;
    logic       playing;
    logic       dead;

    bird_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .flap        (flap),
        .hit         (hit),
        .bird_row    (bird_row),
        .bird_onehot (bird_onehot),
        .playing     (playing),
        .dead        (dead)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         cyc;
        logic [2:0] row;
        logic       pl;
        logic       dd;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_vec;
    int   n_bad;
    exp_t mon_e;
    logic [7:0] mon_oh;

    initial begin
        cyc   = 0;
        n_vec = 0;
        n_bad = 0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation stamped for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e  = q.pop_front();
            mon_oh = 8'd1 << mon_e.row;
            n_vec++;
            if (mon_e.cyc != cyc) begin
                n_bad++;
                $display("FAIL stale cyc=%0d expected at cyc %0d", cyc, mon_e.cyc);
            end
            n_vec++;
            if (bird_row !== mon_e.row) begin
                n_bad++;
                $display("FAIL bird_row cyc=%0d got %0d want %0d", cyc, bird_row, mon_e.row);
            end
            n_vec++;
            if (bird_onehot !== mon_oh) begin
                n_bad++;
                $display("FAIL bird_onehot cyc=%0d got %h want %h", cyc, bird_onehot, mon_oh);
            end
            n_vec++;
            if (playing !== mon_e.pl) begin
                n_bad++;
                $display("FAIL playing cyc=%0d got %b want %b", cyc, playing, mon_e.pl);
            end
            n_vec++;
            if (dead !== mon_e.dd) begin
                n_bad++;
                $display("FAIL dead cyc=%0d got %b want %b", cyc, dead, mon_e.dd);
            end
        end
    end

    // Apply inputs for one clock edge, then release them.
    task automatic tick(input logic f, input logic h, input logic r);
        flap  = f;
        hit   = h;
        reset = r;
        @(posedge clk);
        #1;
        flap  = 1'b0;
        hit   = 1'b0;
        reset = 1'b0;
    endtask

    // Expected outputs right after the edge just applied.
    task automatic expect_out(input logic [2:0] row, input logic pl, input logic dd);
        exp_t e;
        e.cyc = cyc;
        e.row = row;
        e.pl  = pl;
        e.dd  = dd;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [2:0] row, input logic pl, input logic dd);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            expect_out(row, pl, dd);
        end
    endtask

    initial begin
        flap  = 1'b0;
        hit   = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset state and idle hold.
        tick(1'b0, 1'b0, 1'b1);
        expect_out(3'd4, 1'b0, 1'b0);
        idle(20, 3'd4, 1'b0, 1'b0);
        // hit ignored in IDLE.
        tick(1'b0, 1'b1, 1'b0);
        expect_out(3'd4, 1'b0, 1'b0);

        // Flap from IDLE, then free fall to death.
        tick(1'b1, 1'b0, 1'b0);
        expect_out(3'd6, 1'b1, 1'b0);
        for (int k = 1; k <= 56; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (k < 48) expect_out(3'(6 - k / 8), 1'b1, 1'b0);
            else if (k < 56) expect_out(3'd0, 1'b1, 1'b0);
            else expect_out(3'd0, 1'b0, 1'b1);
        end
        idle(5, 3'd0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        expect_out(3'd0, 1'b0, 1'b1);

        // Flap coinciding with a fall step at row 3.
        tick(1'b0, 1'b0, 1'b1);
        expect_out(3'd4, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        expect_out(3'd6, 1'b1, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            expect_out(3'(6 - k / 8), 1'b1, 1'b0);
        end
        idle(7, 3'd3, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        expect_out(3'd5, 1'b1, 1'b0);
        idle(7, 3'd5, 1'b1, 1'b0);
        idle(1, 3'd4, 1'b1, 1'b0);

        // Hit with flap at row 5: dead, frozen, reset recovers.
        tick(1'b0, 1'b0, 1'b1);
        expect_out(3'd4, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        expect_out(3'd6, 1'b1, 1'b0);
        idle(7, 3'd6, 1'b1, 1'b0);
        idle(1, 3'd5, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        expect_out(3'd5, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            expect_out(3'd5, 1'b0, 1'b1);
        end
        tick(1'b0, 1'b1, 1'b0);
        expect_out(3'd5, 1'b0, 1'b1);
        idle(10, 3'd5, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        expect_out(3'd4, 1'b0, 1'b0);

        // Ceiling rule: flap at row 6.
        tick(1'b1, 1'b0, 1'b0);
        expect_out(3'd6, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
`ifdef BIRD_CEIL_KILL_EN
        expect_out(3'd7, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        expect_out(3'd7, 1'b0, 1'b1);
        idle(10, 3'd7, 1'b0, 1'b1);
`else
        expect_out(3'd7, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        expect_out(3'd7, 1'b1, 1'b0);
        idle(7, 3'd7, 1'b1, 1'b0);
        idle(1, 3'd6, 1'b1, 1'b0);
`endif

        // Reset with flap in FLY at row 2.
        tick(1'b0, 1'b0, 1'b1);
        expect_out(3'd4, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        expect_out(3'd6, 1'b1, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            expect_out(3'(6 - k / 8), 1'b1, 1'b0);
        end
        idle(3, 3'd2, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        expect_out(3'd4, 1'b0, 1'b0);
        idle(12, 3'd4, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        expect_out(3'd6, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL unchecked expectation for cyc %0d", mon_e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bird_ctrl.md
BIRD_CTRL -- requirements
Module: bird_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset, with these ports:
- clk  input  1  system clock, all state on posedge
- reset  input  1  synchronous, active-high
- flap  input  1  single-cycle press pulse from the key-press edge stage
- hit  input  1  pipe collision flag from the obstacle stage
- bird_row  output  3  bird vertical position, binary; 0 = bottom row, 7 = top row
- bird_onehot  output  8  one-hot decode of bird_row (bit n set when bird_row = n)
- playing  output  1  high while in FLY
- dead  output  1  high while in DEAD

REQ-002 The block SHALL have these parameters:
- FALL_TICKS, default 8, cycles per one-row fall step; legal range 2..2^24.
- FLAP_ROWS, default 2, rows gained per flap; legal range 1..7.
- START_ROW, default 4, row loaded on reset.

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE, FLY, DEAD.
REQ-004 IDLE: bird_row holds, and the fall counter holds at 0. On flap the FSM SHALL go to FLY, set bird_row to min(bird_row+FLAP_ROWS, 7) and clear the counter. hit is ignored in IDLE.
REQ-005 FLY: the 24-bit fall counter SHALL increment by 1 every cycle. When the counter equals FALL_TICKS-1, the cycle is a fall step and the counter SHALL return to 0.
REQ-006 FLY fall step with bird_row > 0 and no flap or hit: bird_row SHALL decrement by 1.
REQ-007 FLY fall step with bird_row = 0 and no flap or hit: the FSM SHALL go to DEAD and bird_row SHALL stay 0.
REQ-008 FLY flap: bird_row SHALL rise by FLAP_ROWS, with the top-row rule set by REQ-017. The counter SHALL clear to 0. Flap takes priority over a coincident fall step.
REQ-009 FLY hit: the FSM SHALL go to DEAD on the next edge with bird_row unchanged. hit takes priority over flap and over a fall step.
REQ-010 DEAD: bird_row and the counter SHALL hold. flap and hit SHALL be ignored. Only reset leaves DEAD.
REQ-011 Latency: every bird_row, playing and dead change SHALL be visible exactly one cycle after the qualifying input edge. All three outputs SHALL be registered.
REQ-012 bird_onehot SHALL be a combinational decode of registered bird_row with exactly one bit set at all times.
REQ-013 Row arithmetic SHALL be done at 4-bit width so that row+FLAP_ROWS never wraps modulo 8. A decrement below 0 SHALL never occur.

Reset
REQ-014 On reset the block SHALL set: state IDLE, bird_row = START_ROW, counter = 0, playing = 0, dead = 0, bird_onehot = 1<<START_ROW.
REQ-015 Reset asserted in any state, including mid-fall or in DEAD, SHALL take priority over flap and hit in that cycle.
REQ-016 After reset is released, the block SHALL remain in IDLE until a flap.

Configuration
REQ-017 The macro BIRD_CEIL_KILL_EN SHALL control the top-row rule:
- Defined: a flap in FLY with bird_row+FLAP_ROWS > 7 SHALL set bird_row = 7 and go to DEAD. A flap from IDLE still clamps to 7.
- Undefined: bird_row SHALL clamp to 7 and the FSM SHALL stay in FLY.

Verification (defaults: FALL_TICKS=8, FLAP_ROWS=2, START_ROW=4)
REQ-018 Reset for 1 cycle -> bird_row=4, bird_onehot=8'h10, playing=0, dead=0. Hold 20 cycles with no flap -> outputs unchanged.
REQ-019 Single flap pulse from IDLE -> next cycle bird_row=6, playing=1. Then no input -> bird_row=5 at 8 cycles after the flap edge and 0 at 48 cycles; dead=1, playing=0 at 56 cycles, bird_row stays 0.
REQ-020 In FLY at bird_row=3, flap in the same cycle the counter reaches 7 -> bird_row=5, counter=0, next fall step 8 cycles later gives bird_row=4.
REQ-021 In FLY at bird_row=5, flap and hit asserted together -> dead=1, bird_row=5. Further flaps -> no change. Reset -> bird_row=4, dead=0.
REQ-022 In FLY at bird_row=6, flap:
- With BIRD_CEIL_KILL_EN -> bird_row=7, dead=1.
- Without it -> bird_row=7, playing=1.
REQ-023 Reset asserted together with flap in FLY at bird_row=2 -> bird_row=4, state IDLE, playing=0.
